// File: rtl/luma2rgb_if.sv
// rtl/luma2rgb_if.sv - luma input / RGB byte output stream bundle for luma2rgb
`timescale 1ns/1ps
interface luma2rgb_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
    logic [7:0]       data_in;
    logic             valid_in;
    logic             last_in;
    logic             ready_out;
    logic [7:0]       data_out;
    logic             valid_out;
    logic             last_out;
    logic             ready_in;
    logic [LVL_W-1:0] fifo_level;

    modport slave (
        input  data_in, valid_in, last_in, ready_in,
        output ready_out, data_out, valid_out, last_out, fifo_level
    );

    modport master (
        output data_in, valid_in, last_in, ready_in,
        input  ready_out, data_out, valid_out, last_out, fifo_level
    );
endinterface

// File: rtl/luma2rgb.sv
// rtl/luma2rgb.sv - expands 8-bit luma samples into a byte-serial R,G,B stream
`timescale 1ns/1ps
module luma2rgb #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    luma2rgb_if.slave  bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        RED   = 3'b001,
        GREEN = 3'b010,
        BLUE  = 3'b100
    } state_t;

    state_t           state;
    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic [LVL_W-1:0] count_nxt;
    logic             ready_q;
    logic             pix_vld;
    logic             last_q;
    logic [7:0]       pix_q;

    logic push;
    logic xfer;
    logic state_ok;
    logic load_req;
    logic pop;

    // ready_q already excludes the full case, so a pop can never open a same-cycle push slot
    always_comb begin
        push      = bus.valid_in && ready_q;
        xfer      = pix_vld && bus.ready_in;
        state_ok  = (state == RED) || (state == GREEN) || (state == BLUE);
        load_req  = !pix_vld || (xfer && (state == BLUE));
        pop       = state_ok && load_req && (count != '0);
        count_nxt = count + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.last_in, bus.data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            pix_vld <= 1'b0;
            pix_q   <= 8'h00;
            last_q  <= 1'b0;
            state   <= RED;
        end else begin
            count   <= count_nxt;
            ready_q <= (count_nxt < LVL_W'(FIFO_DEPTH));
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (!state_ok) begin
                state   <= RED;
                pix_vld <= 1'b0;
            end else if (pop) begin
                pix_q   <= mem[rd_ptr][7:0];
                last_q  <= mem[rd_ptr][8];
                pix_vld <= 1'b1;
                state   <= RED;
            end else if (xfer) begin
                case (state)
                    RED:     state <= GREEN;
                    GREEN:   state <= BLUE;
                    default: begin
                        // B byte taken with nothing buffered: go idle
                        state   <= RED;
                        pix_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ready_out  = ready_q;
    assign bus.valid_out  = pix_vld;
    assign bus.data_out   = pix_vld ? pix_q : 8'h00;
    assign bus.last_out   = pix_vld && last_q && (state == BLUE);
    assign bus.fifo_level = count;
endmodule

// File: tb/tb_luma2rgb.sv
// tb/tb_luma2rgb.sv - directed self-checking bench for luma2rgb
`timescale 1ns/1ps
module tb_luma2rgb;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    luma2rgb_if #(.FIFO_DEPTH(DEPTH)) bus ();

    luma2rgb #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int last_push_cyc = 0;

    logic [7:0] log_d [$];
    logic       log_l [$];
    int         log_c [$];
    int         lvl_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // inputs only change just after posedge, so the negedge view predicts the next edge
    always @(negedge clk) begin
        if (bus.valid_out && bus.ready_in) begin
            log_d.push_back(bus.data_out);
            log_l.push_back(bus.last_out);
            log_c.push_back(cyc);
        end
        lvl_q.push_back(int'(bus.fifo_level));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] y, input logic l);
        bus.data_in  = y;
        bus.last_in  = l;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ready_out) begin
                @(posedge clk);
                #1;
                bus.valid_in  = 1'b0;
                bus.last_in   = 1'b0;
                bus.data_in   = 8'h00;
                last_push_cyc = cyc;
                return;
            end
        end
        nvec++; nfail++;
        $display("FAIL push_timeout got no ready_out exp accept of %0h", y);
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_bytes(input int base, input int n, input string tag);
        for (int i = 0; i < 400 && (log_d.size() - base) < n; i++) tick();
        repeat (4) tick();
        nvec++;
        if (log_d.size() - base !== n) begin
            nfail++;
            $display("FAIL %s_count got %0d exp %0d", tag, log_d.size() - base, n);
        end
    endtask

    function automatic logic [7:0] ld(input int k);
        return (k < log_d.size()) ? log_d[k] : 8'hxx;
    endfunction

    function automatic logic ll(input int k);
        return (k < log_l.size()) ? log_l[k] : 1'bx;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.data_in = 8'h00; bus.valid_in = 1'b0; bus.last_in = 1'b0; bus.ready_in = 1'b0;
        repeat (3) tick();
        nvec++; if (bus.valid_out !== 1'b0) begin nfail++; $display("FAIL rst_valid got %0b exp 0", bus.valid_out); end
        nvec++; if (bus.data_out !== 8'h00) begin nfail++; $display("FAIL rst_data got %0h exp 00", bus.data_out); end
        nvec++; if (bus.last_out !== 1'b0) begin nfail++; $display("FAIL rst_last got %0b exp 0", bus.last_out); end
        nvec++; if (bus.fifo_level !== 3'd0) begin nfail++; $display("FAIL rst_level got %0d exp 0", bus.fifo_level); end
        rst_n = 1'b1;
        #1;
        nvec++; if (bus.ready_out !== 1'b0) begin nfail++; $display("FAIL rst_ready_early got %0b exp 0", bus.ready_out); end
        tick();
        nvec++; if (bus.ready_out !== 1'b1) begin nfail++; $display("FAIL rst_ready_rise got %0b exp 1", bus.ready_out); end
    endtask

    task automatic test_single();
        int base;
        int p;
        base = log_d.size();
        bus.ready_in = 1'b1;
        push(8'h5A, 1'b1);
        p = last_push_cyc;
        wait_bytes(base, 3, "single");
        for (int i = 0; i < 3; i++) begin
            nvec++; if (ld(base + i) !== 8'h5A) begin nfail++; $display("FAIL single_data[%0d] got %0h exp 5a", i, ld(base + i)); end
            nvec++; if (ll(base + i) !== (i == 2)) begin nfail++; $display("FAIL single_last[%0d] got %0b exp %0b", i, ll(base + i), (i == 2)); end
            nvec++;
            if (base + i >= log_c.size() || log_c[base + i] !== p + 1 + i) begin
                nfail++;
                $display("FAIL single_cycle[%0d] got %0d exp %0d", i, (base + i < log_c.size()) ? log_c[base + i] : -1, p + 1 + i);
            end
        end
        nvec++; if (bus.valid_out !== 1'b0) begin nfail++; $display("FAIL single_idle got %0b exp 0", bus.valid_out); end
    endtask

    task automatic test_stream();
        int base;
        int lb;
        int mx;
        base = log_d.size();
        lb = lvl_q.size();
        bus.ready_in = 1'b1;
        push(8'h10, 1'b0);
        push(8'h20, 1'b0);
        push(8'h30, 1'b1);
        wait_bytes(base, 9, "stream");
        for (int i = 0; i < 9; i++) begin
            logic [7:0] e;
            e = 8'((i / 3 + 1) * 16);
            nvec++; if (ld(base + i) !== e) begin nfail++; $display("FAIL stream_data[%0d] got %0h exp %0h", i, ld(base + i), e); end
            nvec++;
            if (base + i >= log_c.size() || log_c[base + i] !== log_c[base] + i) begin
                nfail++;
                $display("FAIL stream_gap[%0d] got %0d exp %0d", i, (base + i < log_c.size()) ? log_c[base + i] : -1, log_c[base] + i);
            end
        end
        mx = 0;
        for (int i = lb; i < lvl_q.size(); i++) if (lvl_q[i] > mx) mx = lvl_q[i];
        nvec++; if ((mx <= 2) !== 1'b1) begin nfail++; $display("FAIL stream_maxlevel got %0d exp <=2", mx); end
    endtask

    task automatic test_backpressure();
        int base;
        base = log_d.size();
        bus.ready_in = 1'b0;
        fork
            begin
                for (int k = 1; k <= 8; k++) push(8'(k), 1'b0);
            end
            begin
                repeat (10) tick();
                nvec++; if (bus.fifo_level !== 3'd4) begin nfail++; $display("FAIL bp_level got %0d exp 4", bus.fifo_level); end
                nvec++; if (bus.ready_out !== 1'b0) begin nfail++; $display("FAIL bp_ready got %0b exp 0", bus.ready_out); end
                nvec++; if (bus.data_out !== 8'h01) begin nfail++; $display("FAIL bp_hold got %0h exp 01", bus.data_out); end
                nvec++; if (bus.valid_out !== 1'b1) begin nfail++; $display("FAIL bp_valid got %0b exp 1", bus.valid_out); end
                bus.ready_in = 1'b1;
            end
        join
        wait_bytes(base, 24, "bp");
        for (int i = 0; i < 24; i++) begin
            nvec++; if (ld(base + i) !== 8'(i / 3 + 1)) begin nfail++; $display("FAIL bp_data[%0d] got %0h exp %0h", i, ld(base + i), 8'(i / 3 + 1)); end
        end
    endtask

    task automatic test_stall();
        int base;
        base = log_d.size();
        bus.ready_in = 1'b1;
        push(8'hAA, 1'b1);
        for (int i = 0; i < 20 && (log_d.size() - base) < 1; i++) tick();
        bus.ready_in = 1'b0;
        repeat (3) begin
            tick();
            nvec++; if (bus.data_out !== 8'hAA) begin nfail++; $display("FAIL stall_hold got %0h exp aa", bus.data_out); end
            nvec++; if (bus.last_out !== 1'b0) begin nfail++; $display("FAIL stall_last got %0b exp 0", bus.last_out); end
            nvec++; if (log_d.size() - base !== 1) begin nfail++; $display("FAIL stall_taken got %0d exp 1", log_d.size() - base); end
        end
        bus.ready_in = 1'b1;
        wait_bytes(base, 3, "stall");
        for (int i = 0; i < 3; i++) begin
            nvec++; if (ld(base + i) !== 8'hAA) begin nfail++; $display("FAIL stall_data[%0d] got %0h exp aa", i, ld(base + i)); end
            nvec++; if (ll(base + i) !== (i == 2)) begin nfail++; $display("FAIL stall_order[%0d] got %0b exp %0b", i, ll(base + i), (i == 2)); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bus.ready_in = 1'b0;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b1);
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        nvec++; if (bus.fifo_level !== 3'd3) begin nfail++; $display("FAIL rm_level got %0d exp 3", bus.fifo_level); end
        nvec++; if (bus.data_out !== 8'h11) begin nfail++; $display("FAIL rm_gbyte got %0h exp 11", bus.data_out); end
        rst_n = 1'b0;
        #1;
        nvec++; if (bus.valid_out !== 1'b0) begin nfail++; $display("FAIL rm_valid got %0b exp 0", bus.valid_out); end
        nvec++; if (bus.data_out !== 8'h00) begin nfail++; $display("FAIL rm_data got %0h exp 00", bus.data_out); end
        nvec++; if (bus.last_out !== 1'b0) begin nfail++; $display("FAIL rm_last got %0b exp 0", bus.last_out); end
        nvec++; if (bus.ready_out !== 1'b0) begin nfail++; $display("FAIL rm_ready got %0b exp 0", bus.ready_out); end
        nvec++; if (bus.fifo_level !== 3'd0) begin nfail++; $display("FAIL rm_level0 got %0d exp 0", bus.fifo_level); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        base = log_d.size();
        bus.ready_in = 1'b1;
        push(8'h77, 1'b0);
        wait_bytes(base, 3, "rm");
        for (int i = 0; i < 3; i++) begin
            nvec++; if (ld(base + i) !== 8'h77) begin nfail++; $display("FAIL rm_data[%0d] got %0h exp 77", i, ld(base + i)); end
        end
    endtask

    task automatic test_boundaries();
        int base;
        logic [7:0] e;
        base = log_d.size();
        bus.ready_in = 1'b1;
        push(8'h00, 1'b0);
        push(8'hFF, 1'b1);
        wait_bytes(base, 6, "bnd");
        for (int i = 0; i < 6; i++) begin
            e = (i < 3) ? 8'h00 : 8'hFF;
            nvec++; if (ld(base + i) !== e) begin nfail++; $display("FAIL bnd_data[%0d] got %0h exp %0h", i, ld(base + i), e); end
        end

        base = log_d.size();
        bus.ready_in = 1'b0;
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b0);
        nvec++; if (bus.fifo_level !== 3'd2) begin nfail++; $display("FAIL pp_pre got %0d exp 2", bus.fifo_level); end
        bus.ready_in = 1'b1;
        tick();
        tick();
        bus.data_in = 8'hA4; bus.last_in = 1'b0; bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0; bus.data_in = 8'h00;
        nvec++; if (bus.fifo_level !== 3'd2) begin nfail++; $display("FAIL pp_level got %0d exp 2", bus.fifo_level); end
        wait_bytes(base, 12, "pp");
        for (int i = 0; i < 12; i++) begin
            e = 8'hA1 + 8'(i / 3);
            nvec++; if (ld(base + i) !== e) begin nfail++; $display("FAIL pp_data[%0d] got %0h exp %0h", i, ld(base + i), e); end
        end

        base = log_d.size();
        bus.ready_in = 1'b0;
        for (int k = 1; k <= 5; k++) push(8'hB0 + 8'(k), 1'b0);
        bus.data_in = 8'hEE; bus.valid_in = 1'b1;
        repeat (3) tick();
        nvec++; if (bus.fifo_level !== 3'd4) begin nfail++; $display("FAIL full_level got %0d exp 4", bus.fifo_level); end
        nvec++; if (bus.ready_out !== 1'b0) begin nfail++; $display("FAIL full_ready got %0b exp 0", bus.ready_out); end
        bus.valid_in = 1'b0; bus.data_in = 8'h00;
        bus.ready_in = 1'b1;
        wait_bytes(base, 15, "full");
        for (int i = 0; i < 15; i++) begin
            e = 8'hB1 + 8'(i / 3);
            nvec++; if (ld(base + i) !== e) begin nfail++; $display("FAIL full_data[%0d] got %0h exp %0h", i, ld(base + i), e); end
        end
    endtask

    initial begin
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        bus.ready_in = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_boundaries();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
